// File: rtl/vmem_writer.sv
// -----------------------------------------------------------------------------
// vmem_writer
//   Text-terminal writer for the character video memory scanned by the VGA
//   text path. Takes an ASCII byte stream, writes glyph codes at the cursor,
//   handles newline / carriage return / backspace / form-feed, and scrolls the
//   screen up one row when the cursor runs off the bottom.
//
// Ports
//   clk       system clock, all state on posedge
//   reset     asynchronous, active-low reset
//   in_valid  in_char valid
//   in_char   ASCII input byte
//   in_ready  1 in IDLE; a byte is taken on an edge with in_valid & in_ready
//   wr_en     vmem write strobe (registered)
//   wr_addr   vmem write address = row*COLS + col (registered)
//   wr_data   vmem write data (registered)
//   rd_addr   vmem read address; rd_data is valid one cycle later
//   rd_data   vmem read data (used only while scrolling)
//   cursor_x  current column, 0..COLS-1
//   cursor_y  current row, 0..ROWS-1
//   busy      ~in_ready
// -----------------------------------------------------------------------------
module vmem_writer #(
   parameter int COLS   = 70,
   parameter int ROWS   = 30,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_char,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic [6:0]        cursor_x,
   output logic [4:0]        cursor_y,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      SCROLL,
      CLR_ROW,
      CLR_ALL
   } state_t;

   localparam int CELLS    = COLS * ROWS;
   localparam int SCROLL_N = COLS * (ROWS - 1);

   localparam logic [ADDR_W-1:0] A_ONE       = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_COLS      = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0] A_SCROLL_N  = ADDR_W'(SCROLL_N);
   localparam logic [ADDR_W-1:0] A_LAST_BASE = ADDR_W'((ROWS - 1) * COLS);
   localparam logic [ADDR_W-1:0] A_LAST_CELL = ADDR_W'(CELLS - 1);
   localparam logic [6:0]        LAST_COL    = 7'(COLS - 1);
   localparam logic [4:0]        LAST_ROW    = 5'(ROWS - 1);
   localparam logic [7:0]        SPACE       = 8'h20;

   state_t            state;
   logic [ADDR_W-1:0] line_base;  // cursor_y*COLS, tracked by +/-COLS steps
   logic [ADDR_W-1:0] cnt;        // scroll step index or clear address

   assign in_ready = (state == IDLE);
   assign busy     = ~in_ready;

   // NOTE: every register here is plain flop state with a defined reset value;
   // the video memory itself lives outside and is never cleared by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cursor_x  <= '0;
         cursor_y  <= '0;
         line_base <= '0;
         cnt       <= '0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         rd_addr   <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout; a later assignment in the
         // same cycle overrides this default, so the strobe is a one-cycle pulse.
         wr_en <= 1'b0;

         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  if (in_char >= 8'h20 && in_char <= 8'h7E) begin
                     wr_en   <= 1'b1;
                     wr_addr <= line_base + ADDR_W'(cursor_x);
                     wr_data <= in_char;
                     if (cursor_x == LAST_COL) begin
                        cursor_x <= '0;
                        if (cursor_y == LAST_ROW) begin
                           state   <= SCROLL;
                           cnt     <= '0;
                           rd_addr <= A_COLS;
                        end else begin
                           cursor_y  <= cursor_y + 5'd1;
                           line_base <= line_base + A_COLS;
                        end
                     end else begin
                        cursor_x <= cursor_x + 7'd1;
                     end
                  end else if (in_char == 8'h0A || in_char == 8'h0D) begin
                     cursor_x <= '0;
                     if (cursor_y == LAST_ROW) begin
                        state   <= SCROLL;
                        cnt     <= '0;
                        rd_addr <= A_COLS;
                     end else begin
                        cursor_y  <= cursor_y + 5'd1;
                        line_base <= line_base + A_COLS;
                     end
                  end else if (in_char == 8'h08) begin
                     // Backspace erases the cell it moves onto; at (0,0) nothing happens.
                     if (cursor_x != '0) begin
                        cursor_x <= cursor_x - 7'd1;
                        wr_en    <= 1'b1;
                        wr_addr  <= line_base + ADDR_W'(cursor_x) - A_ONE;
                        wr_data  <= SPACE;
                     end else if (cursor_y != '0) begin
                        cursor_x  <= LAST_COL;
                        cursor_y  <= cursor_y - 5'd1;
                        line_base <= line_base - A_COLS;
                        wr_en     <= 1'b1;
                        wr_addr   <= line_base - A_ONE;  // last cell of previous row
                        wr_data   <= SPACE;
                     end
                  end else if (in_char == 8'h0C) begin
                     state <= CLR_ALL;
                     cnt   <= '0;
                  end
               end
            end

            SCROLL: begin
               // Step cnt presents rd_addr = COLS+cnt; the data comes back during
               // step cnt+1 and is written one row up at address cnt.
               if (cnt != '0) begin
                  wr_en   <= 1'b1;
                  wr_addr <= cnt - A_ONE;
                  wr_data <= rd_data;
               end
               if (cnt == A_SCROLL_N) begin
                  state <= CLR_ROW;
                  cnt   <= A_LAST_BASE;
               end else begin
                  cnt <= cnt + A_ONE;
                  // Hold the read address on the last cell rather than run past the screen.
                  if (cnt < A_SCROLL_N - A_ONE) begin
                     rd_addr <= rd_addr + A_ONE;
                  end
               end
            end

            CLR_ROW: begin
               wr_en   <= 1'b1;
               wr_addr <= cnt;
               wr_data <= SPACE;
               if (cnt == A_LAST_CELL) begin
                  state     <= IDLE;
                  cursor_x  <= '0;
                  cursor_y  <= LAST_ROW;
                  line_base <= A_LAST_BASE;
               end else begin
                  cnt <= cnt + A_ONE;
               end
            end

            CLR_ALL: begin
               wr_en   <= 1'b1;
               wr_addr <= cnt;
               wr_data <= SPACE;
               if (cnt == A_LAST_CELL) begin
                  state     <= IDLE;
                  cursor_x  <= '0;
                  cursor_y  <= '0;
                  line_base <= '0;
               end else begin
                  cnt <= cnt + A_ONE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vmem_writer.sv
// -----------------------------------------------------------------------------
// tb_vmem_writer
//   Directed bench for vmem_writer with a behavioural video memory (one write
//   port, one-cycle-latency read port). Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_vmem_writer;

   localparam int COLS  = 70;
   localparam int ROWS  = 30;
   localparam int CELLS = COLS * ROWS;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_char = 8'h00;
   logic        in_ready;
   logic        wr_en;
   logic [11:0] wr_addr;
   logic [7:0]  wr_data;
   logic [11:0] rd_addr;
   logic [7:0]  rd_data;
   logic [6:0]  cursor_x;
   logic [4:0]  cursor_y;
   logic        busy;

   logic        pre_en = 1'b0;   // loads every cell with its row number
   logic [7:0]  mem [0:4095];

   int checks   = 0;
   int failures = 0;
   int oob      = 0;

   always #5 clk = ~clk;

   vmem_writer #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(12)) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_char  (in_char),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .cursor_x (cursor_x),
      .cursor_y (cursor_y),
      .busy     (busy)
   );

   always @(posedge clk) begin
      if (pre_en) begin
         for (int a = 0; a < CELLS; a++) mem[a] <= 8'(a / COLS);
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

   always @(negedge clk) begin
      if (reset && wr_en && wr_addr > 12'(CELLS - 1)) oob++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Returns on the falling edge after acceptance, where the write is visible.
   task automatic send_byte(input logic [7:0] c);
      @(negedge clk);
      in_valid = 1'b1;
      in_char  = c;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag, output int n);
      n = 0;
      while (busy && n < 10000) begin
         @(negedge clk);
         n++;
      end
      check(tag, 32'(busy), 32'd0);
   endtask

   task automatic goto_last_row();
      for (int i = 0; i < ROWS - 1; i++) send_byte(8'h0A);
   endtask

   initial begin
      int bad, n, nwr, done;

      // ---- reset state ----
      do_reset();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_wr_en",    32'(wr_en),    32'd0);
      check("rst_wr_addr",  32'(wr_addr),  32'd0);
      check("rst_wr_data",  32'(wr_data),  32'd0);
      check("rst_rd_addr",  32'(rd_addr),  32'd0);
      check("rst_cursor",   {cursor_y, cursor_x}, {5'd0, 7'd0});

      // ---- backspace at origin is a no-op ----
      send_byte(8'h08);
      check("bs_origin_wr_en",  32'(wr_en), 32'd0);
      check("bs_origin_cursor", {cursor_y, cursor_x}, {5'd0, 7'd0});

      // ---- single printable ----
      send_byte(8'h41);
      check("A_wr_en",   32'(wr_en),   32'd1);
      check("A_wr_addr", 32'(wr_addr), 32'd0);
      check("A_wr_data", 32'(wr_data), 32'h41);
      check("A_cursor",  {cursor_y, cursor_x}, {5'd0, 7'd1});

      // ---- one full row, wrapping to row 1 ----
      do_reset();
      bad = 0;
      for (int i = 0; i < COLS; i++) begin
         send_byte(8'h30 + 8'(i % 10));
         if (!wr_en || wr_addr != 12'(i) || wr_data != 8'h30 + 8'(i % 10) || !in_ready) bad++;
      end
      check("row0_writes",   32'(bad),     32'd0);
      check("row0_last_addr", 32'(wr_addr), 32'd69);
      check("row0_cursor",   {cursor_y, cursor_x}, {5'd1, 7'd0});
      check("row0_in_ready", 32'(in_ready), 32'd1);

      // ---- CR / backspace across a row boundary / ignored byte ----
      send_byte(8'h0A);
      for (int i = 0; i < 5; i++) send_byte(8'h71);
      check("pos_5_2", {cursor_y, cursor_x}, {5'd2, 7'd5});
      send_byte(8'h0D);
      check("cr_wr_en",  32'(wr_en), 32'd0);
      check("cr_cursor", {cursor_y, cursor_x}, {5'd3, 7'd0});
      send_byte(8'h08);
      check("bs_wrap_cursor", {cursor_y, cursor_x}, {5'd2, 7'd69});
      check("bs_wrap_wr",     {23'd0, wr_en, wr_data}, {23'd0, 1'b1, 8'h20});
      check("bs_wrap_addr",   32'(wr_addr), 32'd209);
      send_byte(8'h08);
      check("bs_mid_cursor", {cursor_y, cursor_x}, {5'd2, 7'd68});
      check("bs_mid_addr",   32'(wr_addr), 32'd208);
      send_byte(8'h01);
      check("ignored_wr_en",  32'(wr_en), 32'd0);
      check("ignored_cursor", {cursor_y, cursor_x}, {5'd2, 7'd68});
      check("ignored_ready",  32'(in_ready), 32'd1);

      // ---- newline on the last row scrolls ----
      do_reset();
      goto_last_row();
      check("last_row_cursor", {cursor_y, cursor_x}, {5'd29, 7'd0});
      @(negedge clk);
      pre_en = 1'b1;
      @(negedge clk);
      pre_en = 1'b0;
      send_byte(8'h0A);
      check("scroll_busy", 32'(busy), 32'd1);
      wait_idle("scroll_nl_timeout", n);
      // SCROLL lasts COLS*(ROWS-1)+1 cycles, CLR_ROW COLS cycles.
      check("scroll_busy_len", 32'(n >= 2100 && n <= 2101), 32'd1);
      @(negedge clk);
      bad = 0;
      for (int a = 0; a < CELLS; a++) begin
         if (a < (ROWS - 1) * COLS) begin
            if (mem[a] != 8'(a / COLS + 1)) bad++;
         end else if (mem[a] != 8'h20) bad++;
      end
      check("scroll_nl_mem",    32'(bad), 32'd0);
      check("scroll_nl_cursor", {cursor_y, cursor_x}, {5'd29, 7'd0});
      check("scroll_nl_ready",  32'(in_ready), 32'd1);

      // ---- printable wrap on the last row scrolls ----
      for (int i = 0; i < COLS; i++) send_byte(8'h41 + 8'(i % 26));
      check("scroll_ch_busy", 32'(busy), 32'd1);
      wait_idle("scroll_ch_timeout", n);
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < COLS; i++) begin
         if (mem[(ROWS - 2) * COLS + i] != 8'h41 + 8'(i % 26)) bad++;
         if (mem[(ROWS - 1) * COLS + i] != 8'h20) bad++;
      end
      check("scroll_ch_mem",    32'(bad), 32'd0);
      check("scroll_ch_cursor", {cursor_y, cursor_x}, {5'd29, 7'd0});

      // ---- form feed clears everything; input while busy is ignored ----
      send_byte(8'h0C);
      nwr = 0;
      bad = 0;
      done = 0;
      for (int i = 0; i < 3000 && done == 0; i++) begin
         if (wr_en) begin
            if (wr_addr != 12'(nwr) || wr_data != 8'h20) bad++;
            nwr++;
         end
         if (!busy) done = 1;
         else begin
            in_valid = (i % 7 == 3);
            in_char  = 8'h5A;
            @(negedge clk);
         end
      end
      in_valid = 1'b0;
      check("clr_done",     32'(done), 32'd1);
      check("clr_count",    32'(nwr),  32'd2100);
      check("clr_sequence", 32'(bad),  32'd0);
      check("clr_cursor",   {cursor_y, cursor_x}, {5'd0, 7'd0});
      @(negedge clk);
      check("clr_after_wr_en", 32'(wr_en), 32'd0);
      bad = 0;
      for (int a = 0; a < CELLS; a++) if (mem[a] != 8'h20) bad++;
      check("clr_mem", 32'(bad), 32'd0);

      // ---- reset in the middle of a scroll ----
      do_reset();
      goto_last_row();
      send_byte(8'h0A);
      repeat (100) @(negedge clk);
      check("mid_scroll_busy",  32'(busy),  32'd1);
      check("mid_scroll_wr_en", 32'(wr_en), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("abort_wr_en",  32'(wr_en), 32'd0);
      check("abort_cursor", {cursor_y, cursor_x}, {5'd0, 7'd0});
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_rd_addr",  32'(rd_addr),  32'd0);
      send_byte(8'h42);
      check("abort_write", {wr_en, wr_addr, wr_data}, {1'b1, 12'd0, 8'h42});

      check("addr_in_range", 32'(oob), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
